// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_add_pkg;

    // Operation sequencing: wait for start, walk the bits, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width; kept at least one bit so WIDTH=2 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
interface serial_add_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Requester side.
    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// Combinational full adder from two half-adder stages and an OR.
module fa_cell (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    logic hs_sum;
    logic hs_carry;
    logic hc_carry;

    // First half adder on the operand bits, second folds in the carry.
    always_comb begin
        hs_sum   = a ^ b;
        hs_carry = a & b;
        sum      = hs_sum ^ c_in;
        hc_carry = hs_sum & c_in;
        carry    = hs_carry | hc_carry;
    end
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell reused
// over WIDTH cycles, LSB first, with a registered carry between bits.
module serial_add_sub
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_sub_if.slave  bus
);
    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_add_sub: WIDTH must be within 2..64");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] acc_shifted;

    fa_cell u_fa_cell (
        .sum   (fa_sum),
        .carry (fa_carry),
        .a     (op_a_q[0]),
        .b     (op_b_q[0]),
        .c_in  (carry_q)
    );

    // New bit enters at the MSB so the LSB-first result ends up aligned.
    assign acc_shifted = {fa_sum, acc_q[WIDTH-1:1]};

    // Next-state: operand load, per-bit shift, and result capture on the last bit.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            // DONE also accepts a request so back-to-back ops take WIDTH+1 cycles.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                acc_d   = acc_shifted;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // carry_q here is the carry entering the MSB.
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = acc_shifted;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
